// File: rtl/ipsxb_uart_pkg.sv
// Shared UART definitions: FSM state encoding, err_flags bit positions, frame shape.
// No logic of its own; imported by the FIFO interface top.
package ipsxb_uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    localparam int ERR_OVF   = 0;
    localparam int ERR_FRAME = 1;
    localparam int ERR_PAR   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Parity bit value that makes the total count of ones even (odd=0) or odd (odd=1).
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/ipsxb_sync_fifo.sv
// Synchronous FIFO with first-word fall-through: rd_data shows the head with zero read latency.
// Push while full is dropped unless a pop frees a slot in the same cycle; pop while empty is ignored.
module ipsxb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ipsxb_seu_rs232_fifo_intf.sv
// RS232 UART with TX word FIFO and RX byte FIFO; TX starts one cycle after the first push.
// TX push while full is dropped; RX bytes arriving to a full FIFO are dropped and flagged.
module ipsxb_seu_rs232_fifo_intf
    import ipsxb_uart_pkg::*;
#(
    parameter logic [15:0] CLK_DIV_P    = 16'd145,
    parameter int          TX_BYTES     = 4,
    parameter int          FIFO_DEPTH   = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter bit          TX_MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [8*TX_BYTES-1:0]        tx_wr_data,
    input  logic                         tx_wr_en,
    output logic                         tx_full,
    output logic [$clog2(FIFO_DEPTH):0]  tx_level,
    output logic [7:0]                   rx_rd_data,
    input  logic                         rx_rd_en,
    output logic                         rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]  rx_level,
    output logic [2:0]                   err_flags,
    input  logic                         err_clr,
    output logic                         txd,
    input  logic                         rxd
);
    localparam int          WW        = 8 * TX_BYTES;
    localparam logic [15:0] BIT_LAST  = CLK_DIV_P - 16'd1;
    localparam logic [15:0] HALF_LAST = (CLK_DIV_P >> 1) - 16'd1;

    // ---------------- TX ----------------
    uart_state_t   tx_state, tx_next;
    logic [15:0]   tx_div;
    logic [2:0]    tx_bit;
    logic [2:0]    tx_byte;
    logic [WW-1:0] tx_word;
    logic [WW-1:0] tx_fifo_dat;
    logic [7:0]    tx_cur;
    logic          tx_empty, tx_pop, tx_tick, tx_last_byte, tx_stop_done;

    ipsxb_sync_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tx_wr_en),
        .wr_data (tx_wr_data),
        .rd_en   (tx_pop),
        .rd_data (tx_fifo_dat),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (tx_level)
    );

    // The word register shifts after each byte so the byte on the wire is always at one end.
    assign tx_cur       = TX_MSB_FIRST ? tx_word[WW-1 -: 8] : tx_word[7:0];
    assign tx_tick      = (tx_div == BIT_LAST);
    assign tx_last_byte = (tx_byte == 3'(TX_BYTES - 1));
    assign tx_stop_done = (tx_state == ST_STOP) && tx_tick && (tx_bit == 3'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= ST_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            ST_IDLE:   if (!tx_empty) tx_next = ST_START;
            ST_START:  if (tx_tick) tx_next = ST_DATA;
            ST_DATA:   if (tx_tick && tx_bit == 3'(DATA_BITS - 1))
                           tx_next = PARITY_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tx_tick) tx_next = ST_STOP;
            ST_STOP:   if (tx_stop_done)
                           tx_next = (!tx_last_byte || !tx_empty) ? ST_START : ST_IDLE;
            default:   tx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        txd    = 1'b1;
        tx_pop = 1'b0;
        case (tx_state)
            ST_IDLE:   tx_pop = !tx_empty;
            ST_START:  txd = 1'b0;
            ST_DATA:   txd = tx_cur[tx_bit];
            ST_PARITY: txd = parity_bit(tx_cur, PARITY_ODD);
            ST_STOP:   tx_pop = tx_stop_done && tx_last_byte && !tx_empty;
            default:   txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_div  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
            tx_word <= '0;
        end else begin
            tx_div <= (tx_state == ST_IDLE || tx_tick) ? '0 : tx_div + 16'd1;
            if (tx_tick && tx_state == ST_DATA)
                tx_bit <= (tx_bit == 3'(DATA_BITS - 1)) ? '0 : tx_bit + 3'd1;
            else if (tx_tick && tx_state == ST_STOP)
                tx_bit <= tx_stop_done ? '0 : tx_bit + 3'd1;
            if (tx_pop) begin
                tx_word <= tx_fifo_dat;
                tx_byte <= '0;
            end else if (tx_stop_done) begin
                tx_word <= TX_MSB_FIRST ? (tx_word << 8) : (tx_word >> 8);
                tx_byte <= tx_byte + 3'd1;
            end
        end
    end

    // ---------------- RX ----------------
    uart_state_t rx_state, rx_next;
    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev, rx_fall;
    logic [15:0] rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_par_bad, rx_sample, rx_push, rx_full;
    logic [2:0]  err_set;

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;
    // Start bit is checked at its midpoint; every later sample is one full bit after the last.
    assign rx_sample = (rx_state == ST_START) ? (rx_div == HALF_LAST)
                                              : (rx_state != ST_IDLE && rx_div == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= ST_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            ST_IDLE:   if (rx_fall) rx_next = ST_START;
            ST_START:  if (rx_sample) rx_next = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (rx_sample && rx_bit == 3'(DATA_BITS - 1))
                           rx_next = PARITY_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (rx_sample) rx_next = ST_STOP;
            ST_STOP:   if (rx_sample) rx_next = ST_IDLE;
            default:   rx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_push = 1'b0;
        err_set = '0;
        case (rx_state)
            ST_PARITY: err_set[ERR_PAR] = rx_sample && (rx_s != parity_bit(rx_shift, PARITY_ODD));
            ST_STOP: begin
                if (rx_sample) begin
                    if (!rx_s)            err_set[ERR_FRAME] = 1'b1;
                    else if (!rx_par_bad) begin
                        if (rx_full)      err_set[ERR_OVF] = 1'b1;
                        else              rx_push = 1'b1;
                    end
                end
            end
            default: rx_push = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_div     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
            err_flags  <= '0;
        end else begin
            rx_div <= (rx_state == ST_IDLE || rx_sample) ? '0 : rx_div + 16'd1;
            if (rx_state == ST_START) begin
                rx_bit     <= '0;
                rx_par_bad <= 1'b0;
            end else if (rx_state == ST_DATA && rx_sample) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end else if (err_set[ERR_PAR]) begin
                rx_par_bad <= 1'b1;
            end
            err_flags <= err_clr ? '0 : (err_flags | err_set);
        end
    end

    ipsxb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rx_push),
        .wr_data (rx_shift),
        .rd_en   (rx_rd_en),
        .rd_data (rx_rd_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (rx_level)
    );

endmodule

// File: tb/tb_ipsxb_seu_rs232_fifo_intf.sv
// Directed-plus-random bench: three configurations (plain TX/RX, odd-parity loopback, even-parity RX).
module tb_ipsxb_seu_rs232_fifo_intf;
    localparam int DIV = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: 4-byte words, LSB byte first, depth 4, no parity, rxd driven by the bench
    logic [31:0] a_tx_wr_data = '0;
    logic        a_tx_wr_en = 1'b0, a_rx_rd_en = 1'b0, a_err_clr = 1'b0, a_rxd = 1'b1;
    logic        a_tx_full, a_rx_empty, a_txd;
    logic [2:0]  a_tx_level, a_rx_level, a_err;
    logic [7:0]  a_rx_rd_data;

    ipsxb_seu_rs232_fifo_intf #(.CLK_DIV_P(16'd8), .TX_BYTES(4), .FIFO_DEPTH(4),
        .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .TX_MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_wr_data(a_tx_wr_data), .tx_wr_en(a_tx_wr_en),
        .tx_full(a_tx_full), .tx_level(a_tx_level), .rx_rd_data(a_rx_rd_data),
        .rx_rd_en(a_rx_rd_en), .rx_empty(a_rx_empty), .rx_level(a_rx_level),
        .err_flags(a_err), .err_clr(a_err_clr), .txd(a_txd), .rxd(a_rxd));

    // B: odd parity, MSB byte first, txd looped back to rxd
    logic [31:0] b_tx_wr_data = '0;
    logic        b_tx_wr_en = 1'b0, b_rx_rd_en = 1'b0, b_err_clr = 1'b0;
    logic        b_tx_full, b_rx_empty, b_txd;
    logic [4:0]  b_tx_level, b_rx_level;
    logic [2:0]  b_err;
    logic [7:0]  b_rx_rd_data;

    ipsxb_seu_rs232_fifo_intf #(.CLK_DIV_P(16'd8), .TX_BYTES(4), .FIFO_DEPTH(16),
        .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .TX_MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_wr_data(b_tx_wr_data), .tx_wr_en(b_tx_wr_en),
        .tx_full(b_tx_full), .tx_level(b_tx_level), .rx_rd_data(b_rx_rd_data),
        .rx_rd_en(b_rx_rd_en), .rx_empty(b_rx_empty), .rx_level(b_rx_level),
        .err_flags(b_err), .err_clr(b_err_clr), .txd(b_txd), .rxd(b_txd));

    // C: even parity receiver
    logic [7:0]  c_tx_wr_data = '0;
    logic        c_tx_wr_en = 1'b0, c_rx_rd_en = 1'b0, c_err_clr = 1'b0, c_rxd = 1'b1;
    logic        c_tx_full, c_rx_empty, c_txd;
    logic [3:0]  c_tx_level, c_rx_level;
    logic [2:0]  c_err;
    logic [7:0]  c_rx_rd_data;

    ipsxb_seu_rs232_fifo_intf #(.CLK_DIV_P(16'd8), .TX_BYTES(1), .FIFO_DEPTH(8),
        .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .TX_MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .tx_wr_data(c_tx_wr_data), .tx_wr_en(c_tx_wr_en),
        .tx_full(c_tx_full), .tx_level(c_tx_level), .rx_rd_data(c_rx_rd_data),
        .rx_rd_en(c_rx_rd_en), .rx_empty(c_rx_empty), .rx_level(c_rx_level),
        .err_flags(c_err), .err_clr(c_err_clr), .txd(c_txd), .rxd(c_rxd));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rxd(input int sel, input logic v);
        if (sel == 0) a_rxd = v;
        else          c_rxd = v;
    endtask

    // Serial frame: start 0, data LSB first, optional parity, one stop bit, each DIV cycles.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        set_rxd(sel, 1'b0);
        step(DIV);
        for (int i = 0; i < 8; i++) begin
            set_rxd(sel, d[i]);
            step(DIV);
        end
        if (has_par) begin
            set_rxd(sel, par);
            step(DIV);
        end
        set_rxd(sel, stop);
        step(DIV);
        set_rxd(sel, 1'b1);
    endtask

    task automatic pop_chk(input int sel, input string tag, input logic [7:0] exp);
        if (sel == 0) begin
            chk(tag, a_rx_rd_data, exp);
            a_rx_rd_en = 1'b1; step(1); a_rx_rd_en = 1'b0;
        end else if (sel == 1) begin
            chk(tag, b_rx_rd_data, exp);
            b_rx_rd_en = 1'b1; step(1); b_rx_rd_en = 1'b0;
        end else begin
            chk(tag, c_rx_rd_data, exp);
            c_rx_rd_en = 1'b1; step(1); c_rx_rd_en = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] word;
        logic [39:0] cap;
        logic [7:0]  q[$];
        logic [7:0]  d;
        logic        par;
        int          w;
        int          lows;

        // Reset values while rst_n is held low
        step(2);
        chk("rst_txd", a_txd, 1);
        chk("rst_tx_full", a_tx_full, 0);
        chk("rst_tx_level", a_tx_level, 0);
        chk("rst_rx_empty", a_rx_empty, 1);
        chk("rst_rx_level", a_rx_level, 0);
        chk("rst_err", a_err, 0);
        rst_n = 1'b1;
        step(2);

        // One 4-byte word, LSB byte first, 40 bit periods back-to-back then idle
        word = 32'hA5C3_0F81;
        a_tx_wr_data = word;
        a_tx_wr_en = 1'b1;
        step(1);
        a_tx_wr_en = 1'b0;
        w = 0;
        while (a_txd !== 1'b0 && w < 20) begin
            step(1);
            w++;
        end
        chk("tx_start_latency", w, 1);
        step(DIV / 2);
        for (int i = 0; i < 40; i++) begin
            cap[i] = a_txd;
            step(DIV);
        end
        for (int j = 0; j < 4; j++) begin
            d = 8'(word >> (8 * j));
            chk($sformatf("tx_frame%0d", j), 32'(cap[j*10 +: 10]), {22'd0, 1'b1, d, 1'b0});
        end
        chk("tx_idle_after", a_txd, 1);
        chk("tx_level_after", a_tx_level, 0);

        // Five frames into a depth-4 RX FIFO with no pops
        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom);
            if (k < 4) q.push_back(d);
            send_frame(0, d, 1'b0, 1'b0, 1'b1);
        end
        step(2);
        chk("ovf_level", a_rx_level, 4);
        chk("ovf_flags", a_err, 3'b001);
        for (int k = 0; k < 4; k++) pop_chk(0, $sformatf("ovf_byte%0d", k), q[k]);
        chk("ovf_fifth_absent", a_rx_empty, 1);
        a_rx_rd_en = 1'b1;
        step(1);
        a_rx_rd_en = 1'b0;
        chk("pop_empty_level", a_rx_level, 0);
        chk("ovf_sticky", a_err, 3'b001);
        a_err_clr = 1'b1;
        step(1);
        a_err_clr = 1'b0;
        chk("ovf_clr", a_err, 0);

        // Stop bit 0, then a short low glitch
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        step(DIV);
        chk("frame_err", a_err, 3'b010);
        chk("frame_discard", a_rx_empty, 1);
        a_rxd = 1'b0;
        step(3);
        a_rxd = 1'b1;
        step(3 * DIV);
        chk("glitch_err", a_err, 3'b010);
        chk("glitch_empty", a_rx_empty, 1);
        a_err_clr = 1'b1;
        step(1);
        a_err_clr = 1'b0;
        chk("frame_clr", a_err, 0);
        d = 8'($urandom);
        send_frame(0, d, 1'b0, 1'b0, 1'b1);
        step(2);
        pop_chk(0, "recover_byte", d);

        // Loopback with odd parity, MSB byte first
        q.delete();
        for (int k = 0; k < 2; k++) begin
            word = $urandom;
            b_tx_wr_data = word;
            b_tx_wr_en = 1'b1;
            step(1);
            for (int j = 3; j >= 0; j--) q.push_back(8'(word >> (8 * j)));
        end
        b_tx_wr_en = 1'b0;
        w = 0;
        while (b_rx_level != 5'd8 && w < 3000) begin
            step(1);
            w++;
        end
        step(2);
        chk("loop_level", b_rx_level, 8);
        chk("loop_err", b_err, 0);
        for (int k = 0; k < 8; k++) pop_chk(1, $sformatf("loop_byte%0d", k), q[k]);
        chk("loop_empty", b_rx_empty, 1);
        chk("loop_tx_level", b_tx_level, 0);

        // Even parity: wrong parity discarded, correct parity accepted
        send_frame(2, 8'h03, 1'b1, 1'b1, 1'b1);
        step(2);
        chk("par_err", c_err, 3'b100);
        chk("par_discard", c_rx_empty, 1);
        q.delete();
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            par = 1'($countones(d) % 2);
            q.push_back(d);
            send_frame(2, d, 1'b1, par, 1'b1);
        end
        step(2);
        chk("par_good_level", c_rx_level, 3);
        for (int k = 0; k < 3; k++) pop_chk(2, $sformatf("par_byte%0d", k), q[k]);
        chk("par_sticky", c_err, 3'b100);
        chk("c_tx_idle", c_txd & ~c_tx_full & (c_tx_level == 4'd0), 1);

        // Fill the TX FIFO, push while full, then reset mid-byte-2
        for (int k = 0; k < 6; k++) begin
            a_tx_wr_data = $urandom;
            a_tx_wr_en = 1'b1;
            step(1);
        end
        a_tx_wr_en = 1'b0;
        chk("tx_full", a_tx_full, 1);
        chk("tx_full_level", a_tx_level, 4);
        a_tx_wr_en = 1'b1;
        step(1);
        a_tx_wr_en = 1'b0;
        chk("tx_push_full_ignored", a_tx_level, 4);
        step(100);
        rst_n = 1'b0;
        #1;
        chk("midframe_rst_txd", a_txd, 1);
        chk("midframe_rst_level", a_tx_level, 0);
        step(2);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            if (a_txd !== 1'b1) lows++;
            step(1);
        end
        chk("post_rst_quiet", lows, 0);
        chk("post_rst_level", a_tx_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipsxb_seu_rs232_fifo_intf.md
IPSXB_SEU_RS232_FIFO_INTF -- requirements
Module: ipsxb_seu_rs232_fifo_intf

Interface
REQ-001 Parameter CLK_DIV_P, 16'd145, clk cycles per UART bit; legal range 4..65535.
REQ-002 Parameter TX_BYTES, 4, bytes per TX word; legal range 1..4.
REQ-003 Parameter FIFO_DEPTH, 16, entries per FIFO; power of 2, range 2..1024.
REQ-004 Parameter PARITY_EN, 0, 1 = parity bit inserted and checked.
REQ-005 Parameter PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1).
REQ-006 Parameter TX_MSB_FIRST, 0, 1 = most-significant byte of a TX word sent first.
REQ-007 clk  input  1  system clock.
REQ-008 rst_n  input  1  reset; asynchronous, active-low.
REQ-009 tx_wr_data  input  8*TX_BYTES  TX word.
REQ-010 tx_wr_en  input  1  push tx_wr_data into the TX FIFO.
REQ-011 tx_full  output  1  TX FIFO full.
REQ-012 tx_level  output  clog2(FIFO_DEPTH)+1  TX FIFO occupancy in words.
REQ-013 rx_rd_data  output  8  head of the RX FIFO (first-word fall-through).
REQ-014 rx_rd_en  input  1  pop the RX FIFO head.
REQ-015 rx_empty  output  1  RX FIFO empty.
REQ-016 rx_level  output  clog2(FIFO_DEPTH)+1  RX FIFO occupancy in bytes.
REQ-017 err_flags  output  3  sticky flags: [0] overflow, [1] frame error, [2] parity error.
REQ-018 err_clr  input  1  clear all err_flags.
REQ-019 txd  output  1  serial out; idle high.
REQ-020 rxd  input  1  serial in; asynchronous to clk.

Function
REQ-021 Frame format: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1); every bit lasts exactly CLK_DIV_P clk cycles.
REQ-022 A TX push while tx_full=1 is ignored; FIFO contents and tx_level are unchanged.
REQ-023 TX FSM states: IDLE, START, DATA, PARITY, STOP; in IDLE with the TX FIFO not empty, the FSM pops one word and enters START on the next cycle.
REQ-024 The TX FSM sends TX_BYTES bytes per word in the order set by TX_MSB_FIRST; STOP goes straight to START while bytes remain, with no idle gap.
REQ-025 After the last byte's STOP, the TX FSM returns to IDLE, or loads the next word immediately when the FIFO is not empty.
REQ-026 PARITY state is entered only when PARITY_EN=1.
REQ-027 rxd passes through a 2-flop synchronizer before use.
REQ-028 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-029 RX START: a falling edge in IDLE enters START; rxd is resampled at CLK_DIV_P/2 cycles; if rxd is high, the event is a glitch and the FSM returns to IDLE with no byte and no flag.
REQ-030 RX DATA/PARITY/STOP: each subsequent bit is sampled every CLK_DIV_P cycles from the START mid-bit point.
REQ-031 A stop-bit sample of 0 sets err_flags[1] and discards the byte; the FSM waits for rxd high before accepting a new start.
REQ-032 A parity mismatch sets err_flags[2] and discards the byte.
REQ-033 A good byte is written to the RX FIFO on the stop-sample cycle; if the RX FIFO is full, the byte is dropped and err_flags[0] is set.
REQ-034 An RX pop while rx_empty=1 is ignored.
REQ-035 A simultaneous push and pop on the same FIFO leaves its level unchanged, including at full; at empty, the pushed entry appears on rx_rd_data the next cycle.
REQ-036 Read and write pointers wrap modulo FIFO_DEPTH; levels range 0..FIFO_DEPTH.
REQ-037 err_clr has priority over a same-cycle flag set; flags remain set until err_clr.

Reset
REQ-038 While rst_n=0: txd=1; both FSMs in IDLE; both FIFOs empty (tx_full=0, tx_level=0, rx_empty=1, rx_level=0); err_flags=0; bit counters=0; synchronizer flops=1.
REQ-039 Reset asserted mid-frame aborts the frame immediately; txd returns high within the same cycle, and the partial RX byte is discarded.

Structure
REQ-040 Shared package ipsxb_uart_pkg SHALL hold the FSM state encodings, the err_flags bit indices, and the frame constants (data bits = 8, stop bits = 1).
REQ-041 Both FIFOs SHALL be instances of one sub-module, ipsxb_sync_fifo, parametrised by WIDTH and DEPTH, with first-word fall-through output; the UART FSMs remain in the top module.

Verification
REQ-042 CLK_DIV_P=8, TX_BYTES=4: push 32'hA5C3_0F81 -> txd carries bytes 81,0F,C3,A5 back-to-back over 320 cycles, then idles high.
REQ-043 txd looped to rxd, PARITY_EN=1, PARITY_ODD=1: push 2 words -> rx_level reaches 8, bytes pop in the transmitted order, err_flags=0.
REQ-044 FIFO_DEPTH=4, no pops: drive 5 good frames on rxd -> rx_level=4, err_flags=3'b001, fifth byte absent.
REQ-045 Drive a frame with stop bit 0, then a 3-cycle low glitch -> err_flags=3'b010, rx_empty stays 1, no byte for the glitch; err_clr -> err_flags=0.
REQ-046 PARITY_EN=1, even: frame 0x03 with parity 1 -> err_flags[2]=1, byte discarded; tx_wr_en with tx_full=1 -> tx_level unchanged.
REQ-047 Assert rst_n=0 during the TX DATA state of byte 2 -> txd=1 immediately; tx_level=0, and no further bits are sent after release.
